// File: rtl/calc_tx_formatter_if.sv
// Parser-side operation request and UART-side byte stream for calc_tx_formatter.
// The slave modport is the formatter; the master modport is its environment.
interface calc_tx_formatter_if;
   logic [3:0]  dtype;
   logic [4:0]  operator;
   logic [15:0] src1;
   logic [15:0] src2;
   logic        parser_done;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;

   modport master (
      output dtype, operator, src1, src2, parser_done, tx_ready,
      input  tx_data, tx_valid, busy
   );

   modport slave (
      input  dtype, operator, src1, src2, parser_done, tx_ready,
      output tx_data, tx_valid, busy
   );
endinterface

// File: rtl/calc_tx_formatter.sv
// Computes a 32-bit add/sub/mul/div result and streams it as "XXXXXXXX\r\n" (or "ERR\r\n").
// Define CALC_DIV_EN to build the 16-cycle restoring divider; otherwise operator 4 is an error.
module calc_tx_formatter (
   input logic                clk,
   input logic                rst,
   calc_tx_formatter_if.slave bus
);
   localparam int unsigned OPND_W     = 16;
   localparam int unsigned RES_W      = 32;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned MSG_W      = 80;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned HEX_DIGITS = 8;

   localparam logic [CNT_W-1:0] RES_LEN = CNT_W'(10);
   localparam logic [CNT_W-1:0] ERR_LEN = CNT_W'(5);
   localparam logic [MSG_W-1:0] ERR_MSG = {40'h4552520D0A, 40'h0};

   typedef enum logic [1:0] {IDLE, CALC, DIV, SEND} state_t;

   state_t state, state_next;

   logic [3:0]        dtype_q;
   logic [4:0]        op_q;
   logic [OPND_W-1:0] a_q, b_q;
   logic [MSG_W-1:0]  msg;
   logic [CNT_W-1:0]  cnt;
   logic              tx_valid_q, busy_q;

   logic              sgn, dtype_ok, op_ok, is_div, err, handshake, last_byte;
   logic [RES_W-1:0]  a_ext, b_ext, calc_res;

   function automatic logic [BYTE_W-1:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [MSG_W-1:0] hex_msg(input logic [RES_W-1:0] v);
      logic [MSG_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < HEX_DIGITS; i++)
         m[MSG_W-1-BYTE_W*i -: BYTE_W] = hex_char(v[RES_W-1-4*i -: 4]);
      m[15:0] = 16'h0D0A;
      return m;
   endfunction

   // Operand extension, op decode and the single-cycle arithmetic
   always_comb begin
      sgn       = (dtype_q == 4'd1);
      dtype_ok  = (dtype_q == 4'd1) || (dtype_q == 4'd2);
      is_div    = (op_q == 5'd4);
`ifdef CALC_DIV_EN
      op_ok     = (op_q >= 5'd1) && (op_q <= 5'd4);
`else
      op_ok     = (op_q >= 5'd1) && (op_q <= 5'd3);
`endif
      err       = !dtype_ok || !op_ok || (is_div && (b_q == '0));
      a_ext     = sgn ? {{(RES_W-OPND_W){a_q[OPND_W-1]}}, a_q} : {{(RES_W-OPND_W){1'b0}}, a_q};
      b_ext     = sgn ? {{(RES_W-OPND_W){b_q[OPND_W-1]}}, b_q} : {{(RES_W-OPND_W){1'b0}}, b_q};
      calc_res  = '0;
      case (op_q)
         5'd1:    calc_res = a_ext + b_ext;
         5'd2:    calc_res = a_ext - b_ext;
         5'd3:    calc_res = a_ext * b_ext;
         default: calc_res = '0;
      endcase
      handshake = tx_valid_q && bus.tx_ready;
      last_byte = (cnt == CNT_W'(1));
   end

`ifdef CALC_DIV_EN
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(OPND_W-1);

   logic [OPND_W-1:0] rem, quo, dvs, rem_nx, quo_nx;
   logic [CNT_W-1:0]  div_cnt;
   logic              neg, div_ge;
   logic [OPND_W:0]   div_shift;
   logic [RES_W-1:0]  quo_ext, div_res;

   // One restoring step on magnitudes; quotient sign applied after the last step
   always_comb begin
      div_shift = {rem, quo[OPND_W-1]};
      div_ge    = (div_shift >= {1'b0, dvs});
      rem_nx    = div_ge ? OPND_W'(div_shift - {1'b0, dvs}) : div_shift[OPND_W-1:0];
      quo_nx    = {quo[OPND_W-2:0], div_ge};
      quo_ext   = {{(RES_W-OPND_W){1'b0}}, quo_nx};
      div_res   = neg ? RES_W'(~quo_ext + RES_W'(1)) : quo_ext;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.parser_done) state_next = CALC;
`ifdef CALC_DIV_EN
         CALC: state_next = (!err && is_div) ? DIV : SEND;
         DIV:  if (div_cnt == DIV_LAST) state_next = SEND;
`else
         CALC: state_next = SEND;
`endif
         SEND: if (handshake && last_byte) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand latch, string load, divider iteration and byte shift-out
   always_ff @(posedge clk) begin
      if (rst) begin
         dtype_q    <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         msg        <= '0;
         cnt        <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef CALC_DIV_EN
         rem        <= '0;
         quo        <= '0;
         dvs        <= '0;
         neg        <= 1'b0;
         div_cnt    <= '0;
`endif
      end else begin
         tx_valid_q <= (state_next == SEND);
         busy_q     <= (state_next != IDLE);
         case (state)
            IDLE: if (bus.parser_done) begin
               dtype_q <= bus.dtype;
               op_q    <= bus.operator;
               a_q     <= bus.src1;
               b_q     <= bus.src2;
            end
            CALC: begin
               if (err) begin
                  msg <= ERR_MSG;
                  cnt <= ERR_LEN;
`ifdef CALC_DIV_EN
               end else if (is_div) begin
                  quo     <= (sgn && a_q[OPND_W-1]) ? OPND_W'(~a_q + OPND_W'(1)) : a_q;
                  dvs     <= (sgn && b_q[OPND_W-1]) ? OPND_W'(~b_q + OPND_W'(1)) : b_q;
                  rem     <= '0;
                  neg     <= sgn && (a_q[OPND_W-1] ^ b_q[OPND_W-1]);
                  div_cnt <= '0;
`endif
               end else begin
                  msg <= hex_msg(calc_res);
                  cnt <= RES_LEN;
               end
            end
`ifdef CALC_DIV_EN
            DIV: begin
               rem     <= rem_nx;
               quo     <= quo_nx;
               div_cnt <= div_cnt + CNT_W'(1);
               if (div_cnt == DIV_LAST) begin
                  msg <= hex_msg(div_res);
                  cnt <= RES_LEN;
               end
            end
`endif
            SEND: if (handshake) begin
               msg <= {msg[MSG_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
               cnt <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.tx_data  = msg[MSG_W-1 -: BYTE_W];
   assign bus.tx_valid = tx_valid_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_calc_tx_formatter.sv
// Scoreboard bench for calc_tx_formatter: expected bytes queued at stimulus, popped on each handshake.
// Division expectations follow CALC_DIV_EN exactly as the design does.
module tb_calc_tx_formatter;
   logic clk = 1'b0;
   logic rst = 1'b1;

   calc_tx_formatter_if bus ();

   calc_tx_formatter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   int         n_rx  = 0;
   int         rx_base = 0;
   bit         rand_rdy = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] held_d;
   bit         held_v = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_txt(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   // Reference: SV integer arithmetic on extended operands
   function automatic bit model(input logic [3:0] dt, input logic [4:0] op,
                                input logic [15:0] a, input logic [15:0] b,
                                output logic [31:0] r, output bit div_path);
      longint x, y;
      r = '0;
      div_path = 1'b0;
      if (dt != 4'd1 && dt != 4'd2) return 1'b1;
      if (dt == 4'd1) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'(a);
         y = longint'(b);
      end
      case (op)
         5'd1: r = 32'(x + y);
         5'd2: r = 32'(x - y);
         5'd3: r = 32'(x * y);
`ifdef CALC_DIV_EN
         5'd4: begin
            if (y == 0) return 1'b1;
            div_path = 1'b1;
            r = 32'(x / y);
         end
`endif
         default: return 1'b1;
      endcase
      return 1'b0;
   endfunction

   // Byte monitor: order against scoreboard, stability while stalled
   always @(negedge clk) begin
      if (rst) begin
         held_v = 1'b0;
      end else begin
         if (bus.tx_valid && held_v) chk("hold_stable", 32'(bus.tx_data), 32'(held_d));
         if (bus.tx_valid && bus.tx_ready) begin
            n_rx++;
            if (exp_q.size() == 0) chk("unexpected_byte", 32'(exp_q.size()), 32'd1);
            else                   chk("byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            held_v = 1'b0;
         end else if (bus.tx_valid) begin
            held_v = 1'b1;
            held_d = bus.tx_data;
         end else begin
            held_v = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [3:0] dt, input logic [4:0] op,
                           input logic [15:0] a, input logic [15:0] b, input int lat);
      int cyc;
      rx_base = n_rx;
      bus.dtype = dt;
      bus.operator = op;
      bus.src1 = a;
      bus.src2 = b;
      bus.parser_done = 1'b1;
      tick();
      bus.parser_done = 1'b0;
      bus.dtype = 4'($urandom);
      bus.operator = 5'($urandom);
      bus.src1 = 16'($urandom);
      bus.src2 = 16'($urandom);
      cyc = 1;
      while (!bus.tx_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("latency", 32'(cyc), 32'(lat));
   endtask

   task automatic drain(input int nbytes);
      int cyc = 0;
      while ((exp_q.size() != 0 || bus.tx_valid) && cyc < 500) begin
         if (rand_rdy) bus.tx_ready = 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      bus.tx_ready = 1'b1;
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      chk("byte_count", 32'(n_rx - rx_base), 32'(nbytes));
      chk("busy_after", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0]  dt;
      logic [4:0]  op;
      logic [15:0] a, b;
      logic [31:0] r;
      bit          e, dp;

      bus.tx_ready = 1'b1;
      bus.parser_done = 1'b0;
      bus.dtype = '0;
      bus.operator = '0;
      bus.src1 = '0;
      bus.src2 = '0;
      repeat (3) tick();
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      rst = 1'b0;
      tick();

      push_txt("00000100"); start_op(4'd2, 5'd1, 16'h00FF, 16'h0001, 2); drain(10);
      push_txt("FFFFFFFF"); start_op(4'd1, 5'd2, 16'h0001, 16'h0002, 2); drain(10);
      push_txt("FFFE0001"); start_op(4'd2, 5'd3, 16'hFFFF, 16'hFFFF, 2); drain(10);
`ifdef CALC_DIV_EN
      push_txt("FFFFFFFD"); start_op(4'd1, 5'd4, 16'hFFF9, 16'h0002, 18); drain(10);
      push_txt("00008000"); start_op(4'd1, 5'd4, 16'h8000, 16'hFFFF, 18); drain(10);
      push_txt("0000000D"); start_op(4'd2, 5'd4, 16'hFFFF, 16'h13B1, 18); drain(10);
      push_txt("ERR");      start_op(4'd1, 5'd4, 16'h0005, 16'h0000, 2);  drain(5);
`else
      push_txt("ERR");      start_op(4'd2, 5'd4, 16'h0006, 16'h0002, 2);  drain(5);
`endif
      push_txt("ERR"); start_op(4'd1, 5'd7, 16'h0003, 16'h0004, 2); drain(5);
      push_txt("ERR"); start_op(4'd0, 5'd1, 16'h0003, 16'h0004, 2); drain(5);

      // Stall at byte 3 with a parser_done pulse that must be ignored
      push_txt("00000100");
      start_op(4'd2, 5'd1, 16'h00FF, 16'h0001, 2);
      repeat (3) tick();
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_data", 32'(bus.tx_data), 32'h30);
         chk("bp_valid", 32'(bus.tx_valid), 32'd1);
         bus.parser_done = (i == 2);
         bus.dtype = 4'd2;
         bus.operator = 5'd3;
         tick();
      end
      bus.parser_done = 1'b0;
      bus.tx_ready = 1'b1;
      drain(10);
      tick();
      chk("bp_no_queue", 32'(bus.busy), 32'd0);

      // parser_done coinciding with the final handshake
      push_txt("ERR");
      start_op(4'd3, 5'd1, 16'h0000, 16'h0000, 2);
      repeat (4) tick();
      bus.dtype = 4'd2;
      bus.operator = 5'd1;
      bus.parser_done = 1'b1;
      tick();
      bus.parser_done = 1'b0;
      chk("last_pd_busy", 32'(bus.busy), 32'd0);
      chk("last_pd_valid", 32'(bus.tx_valid), 32'd0);
      tick();
      chk("last_pd_idle", 32'(bus.busy), 32'd0);
      chk("last_pd_bytes", 32'(n_rx - rx_base), 32'd5);

      // Reset while byte 4 is on offer
      push_txt("00000100");
      start_op(4'd2, 5'd1, 16'h00FF, 16'h0001, 2);
      repeat (4) tick();
      rst = 1'b1;
      exp_q.delete();
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_data", 32'(bus.tx_data), 32'd0);
      repeat (3) tick();
      chk("post_rst_valid", 32'(bus.tx_valid), 32'd0);
      push_txt("00000003"); start_op(4'd2, 5'd1, 16'h0001, 16'h0002, 2); drain(10);

      // Reset wins over a simultaneous parser_done
      bus.dtype = 4'd2;
      bus.operator = 5'd1;
      bus.parser_done = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.parser_done = 1'b0;
      tick();
      chk("rst_prio_busy", 32'(bus.busy), 32'd0);

      // Random operations under random backpressure
      rand_rdy = 1'b1;
      for (int k = 0; k < 14; k++) begin
         dt = 4'($urandom_range(0, 3));
         op = 5'($urandom_range(0, 5));
         a  = 16'($urandom);
         b  = (k % 5 == 0) ? 16'h0000 : 16'($urandom);
         e  = model(dt, op, a, b, r, dp);
         if (e) push_txt("ERR");
         else   push_txt($sformatf("%08X", r));
         start_op(dt, op, a, b, dp ? 18 : 2);
         drain(e ? 5 : 10);
      end
      rand_rdy = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/calc_tx_formatter.md
CALC_TX_FORMATTER -- requirements
Module: calc_tx_formatter

Interface
REQ-001 Parameter: none; every width in this document is fixed.
REQ-002 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 dtype  input  4  operand type from the parser: 1 = signed, 2 = unsigned, other = invalid.
REQ-005 operator  input  5  operation code from the parser: 1 = add, 2 = sub, 3 = mul, 4 = div, other = invalid.
REQ-006 src1, src2  input  16 each  operands from the parser.
REQ-007 parser_done  input  1  one-cycle pulse; dtype, operator, src1 and src2 are valid in that cycle.
REQ-008 tx_data  output  8  ASCII byte offered to the UART transmitter.
REQ-009 tx_valid  output  1  tx_data is valid.
REQ-010 tx_ready  input  1  the transmitter accepts tx_data.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The state machine SHALL use four states: IDLE, CALC, DIV and SEND.
REQ-013 IDLE: parser_done=1 SHALL latch all four inputs and move to CALC on the next edge.
REQ-014 Operand extension: dtype 1 sign-extends both operands to 32 bits; dtype 2 zero-extends them.
REQ-015 Arithmetic: the 32-bit result SHALL be the extended operands combined by the selected op, modulo 2^32.
REQ-016 CALC (1 cycle), add/sub/mul: compute result, load the 8-digit hex string, go to SEND.
REQ-017 CALC, div with src2 != 0: go to DIV.
REQ-018 CALC, error case: load the error string and go to SEND. Error cases are dtype invalid, operator invalid, or div with src2 = 0.
REQ-019 DIV SHALL run a restoring divider on magnitudes for exactly 16 cycles.
REQ-020 Division result: quotient only, truncated toward zero, sign = sign(src1) XOR sign(src2) when signed.
REQ-021 Division range: -32768 / -1 SHALL give 0x00008000.
REQ-022 Result string: 8 uppercase hex ASCII digits, MSB nibble first, then 0x0D, then 0x0A (10 bytes).
REQ-023 Error string: 0x45 0x52 0x52 0x0D 0x0A ("ERR", CR, LF).
REQ-024 SEND: tx_valid=1; a byte SHALL advance only on a cycle with tx_valid and tx_ready both high.
REQ-025 SEND: tx_data SHALL stay stable while tx_ready=0.
REQ-026 SEND: after the last byte is accepted, go to IDLE with tx_valid=0 on the next cycle.
REQ-027 Latency, parser_done at cycle N: first tx_valid at N+2 for add/sub/mul/error, N+18 for div.
REQ-028 parser_done while busy=1 SHALL be ignored, with no latch and no queueing.
REQ-029 parser_done in the same cycle as the final byte handshake SHALL be ignored.

Reset
REQ-030 rst=1 SHALL force state IDLE, tx_valid=0, tx_data=0x00, busy=0, and clear the byte index and divider registers.
REQ-031 Reset mid-DIV or mid-SEND SHALL abort the remaining string; no further byte SHALL be offered after reset.
REQ-032 rst has priority over parser_done in the same cycle.

Configuration
REQ-033 Macro CALC_DIV_EN defined: the DIV state and divider are built and operator 4 behaves per REQ-017 to REQ-021.
REQ-034 Macro CALC_DIV_EN undefined: no divider logic is built; operator 4 is an error case and sends "ERR" with N+2 latency.

Verification
REQ-035 Unsigned add: dtype=2, op=1, 0x00FF+0x0001 -> bytes 30 30 30 30 30 31 30 30 0D 0A, first tx_valid at N+2.
REQ-036 Signed sub and unsigned mul: dtype=1, op=2, 0x0001-0x0002 -> "FFFFFFFF\r\n"; dtype=2, op=3, 0xFFFF*0xFFFF -> "FFFE0001\r\n".
REQ-037 Signed div: dtype=1, op=4, 0xFFF9/0x0002 -> "FFFFFFFD\r\n", first tx_valid at N+18; 0x8000/0xFFFF -> "00008000\r\n".
REQ-038 Error cases: div by 0 -> 45 52 52 0D 0A; operator=7 -> same; without CALC_DIV_EN, op=4, 0x0006/0x0002 -> "ERR\r\n".
REQ-039 Backpressure: tx_ready=0 for 5 cycles at byte 3 -> tx_data holds 0x30, no skipped or duplicated bytes; parser_done pulsed mid-SEND -> ignored, exactly 10 bytes sent.
REQ-040 Reset mid-operation: rst=1 at byte 4 of SEND -> tx_valid=0 next cycle, busy=0; a new parser_done afterwards -> full new string from byte 0.
